// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bank between two requesters.
// Grants are bounded bursts in one direction, with a forced idle gap after output bursts.
module uio_bus_arbiter #(
    parameter int unsigned HOLD_MAX    = 4,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    input  logic [1:0] dir,
    input  logic [7:0] data_out0,
    input  logic [7:0] data_out1,
    input  logic [7:0] uio_in,
    output logic [1:0] gnt,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] rd_data,
    output logic [1:0] rd_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    localparam logic [4:0] HOLD_LIM = 5'(HOLD_MAX);
    localparam logic [3:0] TURN_LIM = 4'(TURN_CYCLES);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       owner_q, owner_d;
    logic       odir_q, odir_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic [2:0] tcnt_q, tcnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] uio_out_q, uio_out_d;
    logic [7:0] uio_oe_q, uio_oe_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [1:0] rd_valid_q, rd_valid_d;

    logic       other;
    logic       winner;
    logic       exit_burst;
    logic [7:0] beat_data;
    logic [4:0] bcnt_inc;
    logic [3:0] tcnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            odir_q     <= 1'b0;
            bcnt_q     <= 4'd0;
            tcnt_q     <= 3'd0;
            gnt_q      <= 2'b00;
            uio_out_q  <= 8'h00;
            uio_oe_q   <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            odir_q     <= odir_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            gnt_q      <= gnt_d;
            uio_out_q  <= uio_out_d;
            uio_oe_q   <= uio_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        odir_d     = odir_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        gnt_d      = gnt_q;
        uio_out_d  = uio_out_q;
        uio_oe_d   = uio_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 2'b00;
        exit_burst = 1'b0;

        other     = ~owner_q;
        // A lone requester wins outright; the pointer only breaks ties.
        winner    = (req == 2'b11) ? ptr_q : req[1];
        beat_data = owner_q ? data_out1 : data_out0;
        bcnt_inc  = {1'b0, bcnt_q} + 5'd1;
        tcnt_inc  = {1'b0, tcnt_q} + 4'd1;

        if (!ena) begin
            state_d  = ST_IDLE;
            gnt_d    = 2'b00;
            uio_oe_d = 8'h00;
            bcnt_d   = 4'd0;
            tcnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt_d   = winner ? 2'b10 : 2'b01;
                        owner_d = winner;
                        odir_d  = dir[winner];
                        bcnt_d  = 4'd0;
                        state_d = ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!req[owner_q]) begin
                        exit_burst = 1'b1;
                    end else if (gnt_q[owner_q]) begin
                        if (odir_q) begin
                            uio_out_d = beat_data;
                            uio_oe_d  = 8'hFF;
                        end else begin
                            rd_data_d           = uio_in;
                            rd_valid_d[owner_q] = 1'b1;
                        end
                        if ({1'b0, bcnt_q} != HOLD_LIM) begin
                            bcnt_d = bcnt_inc[3:0];
                        end
                        // Preemption only happens on the exact beat that hits the limit.
                        if ((bcnt_inc == HOLD_LIM) && req[other]) begin
                            exit_burst = 1'b1;
                        end
                    end
                    if (exit_burst) begin
                        gnt_d = 2'b00;
                        ptr_d = other;
                        if (odir_q) begin
                            state_d = ST_TURN;
                            tcnt_d  = 3'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_TURN: begin
                    uio_oe_d = 8'h00;
                    tcnt_d   = tcnt_q + 3'd1;
                    if (tcnt_inc == TURN_LIM) begin
                        state_d = ST_IDLE;
                        tcnt_d  = 3'd0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    gnt_d    = 2'b00;
                    uio_oe_d = 8'h00;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign uio_out  = uio_out_q;
    assign uio_oe   = uio_oe_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Pad enables are all-or-nothing and at most one requester owns the bus.
    assert property (@(posedge clk) disable iff (!rst_n) (uio_oe_q == 8'h00) || (uio_oe_q == 8'hFF));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: each driven cycle queues the outputs
// expected after the next rising edge, and a monitor pops and compares them.
module tb_uio_bus_arbiter;

   typedef struct packed {
      logic [1:0] gnt;
      logic [7:0] oe;
      logic [7:0] out;
      logic [1:0] rv;
      logic [7:0] rd;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [1:0] req;
   logic [1:0] dir;
   logic [7:0] dataOut0;
   logic [7:0] dataOut1;
   logic [7:0] uioIn;
   logic [1:0] gnt;
   logic [7:0] uioOut;
   logic [7:0] uioOe;
   logic [7:0] rdData;
   logic [1:0] rdValid;

   exp_t expQ[$];
   int   vectorCount = 0;
   int   miscompares = 0;
   int   stepNum = 0;

   uio_bus_arbiter #(.HOLD_MAX(4), .TURN_CYCLES(1)) dut (
      .clk(clock),
      .rst_n(rst_n),
      .ena(ena),
      .req(req),
      .dir(dir),
      .data_out0(dataOut0),
      .data_out1(dataOut1),
      .uio_in(uioIn),
      .gnt(gnt),
      .uio_out(uioOut),
      .uio_oe(uioOe),
      .rd_data(rdData),
      .rd_valid(rdValid)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Every comparison funnels through here so the counts stay consistent.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs and queues what the outputs must be after the next edge.
   task automatic applyStimulus(input logic en, input logic [1:0] rq, input logic [1:0] dr,
                                input logic [7:0] inByte, input logic [1:0] eGnt,
                                input logic [7:0] eOe, input logic [7:0] eOut,
                                input logic [1:0] eRv, input logic [7:0] eRd);
      exp_t e;
      ena   = en;
      req   = rq;
      dir   = dr;
      uioIn = inByte;
      e.gnt = eGnt;
      e.oe  = eOe;
      e.out = eOut;
      e.rv  = eRv;
      e.rd  = eRd;
      expQ.push_back(e);
      @(posedge clock);
      @(negedge clock);
   endtask

   // Monitor samples just after each rising edge and checks against the queue head.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         stepNum++;
         checkOutput($sformatf("gnt#%0d", stepNum), {6'd0, gnt}, {6'd0, e.gnt});
         checkOutput($sformatf("oe#%0d", stepNum), uioOe, e.oe);
         checkOutput($sformatf("out#%0d", stepNum), uioOut, e.out);
         checkOutput($sformatf("rv#%0d", stepNum), {6'd0, rdValid}, {6'd0, e.rv});
         checkOutput($sformatf("rd#%0d", stepNum), rdData, e.rd);
      end
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios; expected values come from the arbitration timing rules.
   initial begin
      logic [1:0] g;
      logic [7:0] d;
      logic [7:0] lastOut;

      rst_n    = 1'b0;
      ena      = 1'b1;
      req      = 2'b11;
      dir      = 2'b11;
      dataOut0 = 8'hA5;
      dataOut1 = 8'h3C;
      uioIn    = 8'h00;

      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rstGnt", {6'd0, gnt}, 8'h00);
      checkOutput("rstOe", uioOe, 8'h00);
      checkOutput("rstOut", uioOut, 8'h00);
      checkOutput("rstRd", rdData, 8'h00);
      checkOutput("rstRv", {6'd0, rdValid}, 8'h00);
      rst_n = 1'b1;

      // Both output requesters held: bounded bursts, turnaround gap, alternating grants.
      lastOut = 8'h00;
      for (int r = 0; r < 3; r++) begin
         g = (r % 2 == 1) ? 2'b10 : 2'b01;
         d = (r % 2 == 1) ? 8'h3C : 8'hA5;
         applyStimulus(1'b1, 2'b11, 2'b11, 8'h00, g, 8'h00, lastOut, 2'b00, 8'h00);
         for (int b = 0; b < 3; b++)
            applyStimulus(1'b1, 2'b11, 2'b11, 8'h00, g, 8'hFF, d, 2'b00, 8'h00);
         applyStimulus(1'b1, 2'b11, 2'b11, 8'h00, 2'b00, 8'hFF, d, 2'b00, 8'h00);
         applyStimulus(1'b1, (r == 2) ? 2'b00 : 2'b11, 2'b11, 8'h00, 2'b00, 8'h00, d, 2'b00, 8'h00);
         lastOut = d;
      end
      applyStimulus(1'b1, 2'b00, 2'b11, 8'h00, 2'b00, 8'h00, 8'hA5, 2'b00, 8'h00);

      // Requester 0 alone: no preemption past the hold limit, then release and turnaround.
      dataOut0 = 8'h77;
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'h00, 8'hA5, 2'b00, 8'h00);
      for (int b = 0; b < 9; b++)
         applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'hFF, 8'h77, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 2'b00, 8'hFF, 8'h77, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 2'b00, 8'h00, 8'h77, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 2'b00, 8'h00, 8'h77, 2'b00, 8'h00);

      // Requester 1 input burst with stepping pad data; requester 0 waits and takes over.
      applyStimulus(1'b1, 2'b10, 2'b00, 8'h00, 2'b10, 8'h00, 8'h77, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b10, 2'b00, 8'h00, 2'b10, 8'h00, 8'h77, 2'b10, 8'h00);
      applyStimulus(1'b1, 2'b10, 2'b00, 8'h01, 2'b10, 8'h00, 8'h77, 2'b10, 8'h01);
      applyStimulus(1'b1, 2'b11, 2'b00, 8'h02, 2'b10, 8'h00, 8'h77, 2'b10, 8'h02);
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h03, 2'b00, 8'h00, 8'h77, 2'b00, 8'h02);
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h04, 2'b01, 8'h00, 8'h77, 2'b00, 8'h02);

      // Enable dropped mid output burst: no beat on that edge, then a fresh grant.
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'hFF, 8'h77, 2'b00, 8'h02);
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'hFF, 8'h77, 2'b00, 8'h02);
      dataOut0 = 8'hC3;
      applyStimulus(1'b0, 2'b01, 2'b01, 8'h00, 2'b00, 8'h00, 8'h77, 2'b00, 8'h02);
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'h00, 8'h77, 2'b00, 8'h02);
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'hFF, 8'hC3, 2'b00, 8'h02);

      // Reset pulsed between edges must clear outputs without a clock edge.
      #1 rst_n = 1'b0;
      #1;
      checkOutput("asyncGnt", {6'd0, gnt}, 8'h00);
      checkOutput("asyncOe", uioOe, 8'h00);
      checkOutput("asyncOut", uioOut, 8'h00);
      checkOutput("asyncRd", rdData, 8'h00);
      #1 rst_n = 1'b1;
      applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00);

      // Grant to 0 moves the pointer; a simultaneous request then goes to 1, dir changes ignored.
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'h00, 8'h00, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b01, 2'b01, 8'h00, 2'b01, 8'hFF, 8'hC3, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 2'b00, 8'hFF, 8'hC3, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 2'b00, 8'h00, 8'hC3, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b11, 2'b11, 8'h00, 2'b10, 8'h00, 8'hC3, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b11, 2'b11, 8'h00, 2'b10, 8'hFF, 8'h3C, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b11, 2'b00, 8'h00, 2'b10, 8'hFF, 8'h3C, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b11, 2'b00, 8'h00, 2'b10, 8'hFF, 8'h3C, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b11, 2'b00, 8'h00, 2'b00, 8'hFF, 8'h3C, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h3C, 2'b00, 8'h00);
      applyStimulus(1'b1, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 8'h3C, 2'b00, 8'h00);

      @(posedge clock);
      #2;
      checkOutput("sbDrain", 8'(expQ.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
      $finish;
   end

endmodule
